digit_stream_decoder: RTL and testbench

Receive-side checker and decoder for the 3-bit octal digit stream produced by the team's matriculation-sequence FSM generators (digits 0→3→{2,5}→…). It samples one digit per valid cycle and validates each transition against the generator's state diagram. From the two branching transitions it recovers the generator's input bit `a`, and it shifts recovered bits into a word. It sits at the far end of the generator output, so the generator and decoder can be checked against each other in one bench.

---
 rtl/fsm_digit_pkg.sv | 17 +
 rtl/fsm_digit_succ.sv | 38 +++
 rtl/digit_stream_decoder.sv | 107 ++++++++++
 tb/tb_digit_stream_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_digit_pkg.sv
// Digit encoding and decoder state type shared by the matriculation-sequence
// generators, the stream decoder and their benches.
package fsm_digit_pkg;

    localparam logic [2:0] D0 = 3'd0;
    localparam logic [2:0] D2 = 3'd2;
    localparam logic [2:0] D3 = 3'd3;
    localparam logic [2:0] D4 = 3'd4;
    localparam logic [2:0] D5 = 3'd5;

    typedef enum logic [1:0] {
        TRACK,
        HUNT,
        CONFIRM
    } dec_state_t;

endpackage

// File: rtl/fsm_digit_succ.sv
// Combinational transition table of the generator's state diagram: digit
// legality, legal successor of prev, and the a bit carried by branch transitions.
module fsm_digit_succ
    import fsm_digit_pkg::*;
(
    input  logic [2:0] prev,
    input  logic [2:0] d,
    output logic       legal_digit,
    output logic       legal_succ,
    output logic       info,
    output logic       a_bit
);

    always_comb begin
        legal_digit = (d == D0) || (d == D2) || (d == D3) || (d == D4) || (d == D5);
        legal_succ  = 1'b0;
        info        = 1'b0;
        a_bit       = 1'b0;
        // No digit lists itself as a successor, so a repeat is always illegal.
        case (prev)
            D0: legal_succ = (d == D3);
            D2: legal_succ = (d == D4);
            D5: legal_succ = (d == D2);
            D3: begin
                legal_succ = (d == D2) || (d == D5);
                info       = legal_succ;
                a_bit      = (d == D5);
            end
            D4: begin
                legal_succ = (d == D0) || (d == D3);
                info       = legal_succ;
                a_bit      = (d == D3);
            end
            default: legal_succ = 1'b0;
        endcase
    end

endmodule

// File: rtl/digit_stream_decoder.sv
// Receive-side checker for the octal digit stream: validates transitions,
// recovers the generator's a bit and tracks lock / error statistics.
module digit_stream_decoder
    import fsm_digit_pkg::*;
#(
    parameter int ERR_W  = 8,
    parameter int BITS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [2:0]        d,
    output logic              a_out,
    output logic              a_valid,
    output logic              err,
    output logic              locked,
    output logic [ERR_W-1:0]  err_count,
    output logic [BITS_W-1:0] bits,
    output logic [3:0]        bit_count
);

    localparam logic [3:0] CNT_MAX = 4'(BITS_W);

    dec_state_t state;
    logic [2:0] prev;
    logic       legal_digit;
    logic       legal_succ;
    logic       info;
    logic       a_bit;
    logic       accept;

    fsm_digit_succ u_succ (
        .prev        (prev),
        .d           (d),
        .legal_digit (legal_digit),
        .legal_succ  (legal_succ),
        .info        (info),
        .a_bit       (a_bit)
    );

    // A legal successor is processed identically whether seen in TRACK or CONFIRM.
    assign accept = d_valid && legal_succ && (state == TRACK || state == CONFIRM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= TRACK;
            prev      <= D0;
            locked    <= 1'b1;
            a_out     <= 1'b0;
            a_valid   <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            bits      <= '0;
            bit_count <= '0;
        end else begin
            a_valid <= 1'b0;
            err     <= 1'b0;

            if (d_valid) begin
                case (state)
                    TRACK: begin
                        if (!legal_succ) begin
                            err       <= 1'b1;
                            state     <= HUNT;
                            locked    <= 1'b0;
                            bit_count <= '0;
                            if (err_count != '1)
                                err_count <= err_count + 1'b1;
                        end
                    end
                    HUNT: begin
                        if (legal_digit) begin
                            prev  <= d;
                            state <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (legal_succ) begin
                            state  <= TRACK;
                            locked <= 1'b1;
                        end else if (legal_digit) begin
                            prev <= d;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end

            if (accept) begin
                prev <= d;
                if (info) begin
                    a_valid <= 1'b1;
                    a_out   <= a_bit;
                    bits    <= {bits[BITS_W-2:0], a_bit};
                    if (bit_count != CNT_MAX)
                        bit_count <= bit_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_stream_decoder.sv
// Scoreboard bench for digit_stream_decoder: stimulus pushes expected pulses,
// a negedge monitor pops and compares them as the DUT emits a_valid / err.
module tb_digit_stream_decoder;

    localparam int ERR_W  = 8;
    localparam int BITS_W = 8;

    localparam int K_NONE = 0;
    localparam int K_A    = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        bit   is_err;
        logic a;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_valid;
    logic [2:0]        d;
    logic              a_out;
    logic              a_valid;
    logic              err;
    logic              locked;
    logic [ERR_W-1:0]  err_count;
    logic [BITS_W-1:0] bits;
    logic [3:0]        bit_count;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    digit_stream_decoder #(.ERR_W(ERR_W), .BITS_W(BITS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .d         (d),
        .a_out     (a_out),
        .a_valid   (a_valid),
        .err       (err),
        .locked    (locked),
        .err_count (err_count),
        .bits      (bits),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && (a_valid === 1'b1 || err === 1'b1)) begin
            if (a_valid === 1'b1 && err === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL both_pulses: a_valid=1 err=1 at %0t", $time);
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: a_valid=%0b err=%0b, expected none at %0t",
                         a_valid, err, $time);
            end else begin
                e = q.pop_front();
                check_eq("pulse_kind_err", err, e.is_err);
                if (!e.is_err)
                    check_eq("a_out", a_out, e.a);
            end
        end
    end

    task automatic send(input logic [2:0] v, input int kind, input logic av);
        exp_t e;
        @(negedge clk);
        d_valid = 1'b1;
        d       = v;
        if (kind != K_NONE) begin
            e.is_err = (kind == K_ERR);
            e.a      = av;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            d_valid = 1'b0;
            d       = 3'd1;
        end
    endtask

    // Let outstanding pulses reach the monitor, then require none left unseen.
    task automatic drain(input string name);
        idle(2);
        #1;
        check_eq(name, q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        d_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_a_out", a_out, 0);
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_locked", locked, 1);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_bits", bits, 0);
        check_eq("rst_bit_count", bit_count, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [2:0] gen_next(input logic [2:0] cur, input logic a);
        case (cur)
            3'd0:    return 3'd3;
            3'd3:    return a ? 3'd5 : 3'd2;
            3'd2:    return 3'd4;
            3'd4:    return a ? 3'd3 : 3'd0;
            3'd5:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    initial begin
        logic [2:0]        cur;
        logic [2:0]        nxt;
        logic              ga;
        logic [BITS_W-1:0] exp_bits;
        int                exp_cnt;

        reset   = 1'b0;
        d_valid = 1'b0;
        d       = 3'd0;

        // Basic a=0 stream.
        do_reset();
        send(3'd3, K_NONE, 0);
        send(3'd2, K_A,    0);
        send(3'd4, K_NONE, 0);
        send(3'd0, K_A,    0);
        send(3'd3, K_NONE, 0);
        drain("t1_queue");
        check_eq("t1_bits", bits, 0);
        check_eq("t1_bit_count", bit_count, 2);
        check_eq("t1_err_count", err_count, 0);
        check_eq("t1_locked", locked, 1);

        // a=1 stream.
        do_reset();
        send(3'd3, K_NONE, 0);
        send(3'd5, K_A,    1);
        send(3'd2, K_NONE, 0);
        send(3'd4, K_NONE, 0);
        send(3'd3, K_A,    1);
        send(3'd5, K_A,    1);
        drain("t2_queue");
        check_eq("t2_bits", bits, 8'b111);
        check_eq("t2_bit_count", bit_count, 3);
        check_eq("t2_locked", locked, 1);

        // Illegal digit, hunt and re-lock.
        send(3'd2, K_NONE, 0);
        send(3'd6, K_ERR,  0);
        drain("t3a_queue");
        check_eq("t3_err_count", err_count, 1);
        check_eq("t3_unlocked", locked, 0);
        send(3'd7, K_NONE, 0);
        send(3'd2, K_NONE, 0);
        send(3'd4, K_NONE, 0);
        drain("t3b_queue");
        check_eq("t3_relocked", locked, 1);
        check_eq("t3_err_count_hold", err_count, 1);
        check_eq("t3_bits_hold", bits, 8'b111);
        check_eq("t3_bit_count_clr", bit_count, 0);

        // Repeat error, then saturate the error counter.
        send(3'd3, K_A,   1);
        send(3'd3, K_ERR, 0);
        for (int i = 0; i < 300; i++) begin
            send(3'd2, K_NONE, 0);
            send(3'd4, K_NONE, 0);
            send(3'd4, K_ERR,  0);
        end
        drain("t4_queue");
        check_eq("t4_err_sat", err_count, 255);
        check_eq("t4_unlocked", locked, 0);
        check_eq("t4_bits", bits, 8'b1111);

        // d_valid low mid-stream holds everything.
        do_reset();
        send(3'd3, K_NONE, 0);
        send(3'd5, K_A,    1);
        send(3'd2, K_NONE, 0);
        idle(5);
        drain("t5a_queue");
        check_eq("t5_bits_hold", bits, 1);
        check_eq("t5_cnt_hold", bit_count, 1);
        check_eq("t5_err_hold", err_count, 0);
        check_eq("t5_locked_hold", locked, 1);
        send(3'd4, K_NONE, 0);
        send(3'd3, K_A,    1);
        drain("t5b_queue");
        check_eq("t5_bits", bits, 8'b11);
        check_eq("t5_bit_count", bit_count, 2);
        check_eq("t5_err_count", err_count, 0);

        // Mid-stream reset right after a pulsing digit 5.
        send(3'd5, K_A, 1);
        do_reset();
        send(3'd3, K_NONE, 0);
        drain("t6a_queue");
        check_eq("t6_locked", locked, 1);
        check_eq("t6_err_count", err_count, 0);

        // 0 right after reset is a repeat; exercise CONFIRM branches.
        do_reset();
        send(3'd0, K_ERR,  0);
        send(3'd3, K_NONE, 0);
        send(3'd0, K_NONE, 0);
        send(3'd7, K_NONE, 0);
        send(3'd3, K_NONE, 0);
        send(3'd5, K_A,    1);
        drain("t6b_queue");
        check_eq("t6_relock", locked, 1);
        check_eq("t6_err_count1", err_count, 1);
        check_eq("t6_bits", bits, 1);
        check_eq("t6_bit_count", bit_count, 1);

        // Generator-driven stream with the a pattern 0x8, 1x16, 0x12, 1x4.
        do_reset();
        cur      = 3'd0;
        exp_bits = '0;
        exp_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            ga  = (i < 8) ? 1'b0 : (i < 24) ? 1'b1 : (i < 36) ? 1'b0 : 1'b1;
            nxt = gen_next(cur, ga);
            if (cur == 3'd3 || cur == 3'd4) begin
                send(nxt, K_A, ga);
                exp_bits = {exp_bits[BITS_W-2:0], ga};
                if (exp_cnt < BITS_W) exp_cnt++;
            end else begin
                send(nxt, K_NONE, 0);
            end
            cur = nxt;
        end
        drain("t7_queue");
        check_eq("t7_err_count", err_count, 0);
        check_eq("t7_locked", locked, 1);
        check_eq("t7_bits", bits, exp_bits);
        check_eq("t7_bit_count", bit_count, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
